// File: rtl/mem_pkg.sv
// mem_pkg: shared bus constants and responder FSM states.
package mem_pkg;
    localparam int BUS_W = 64;
    localparam int OFF_W = 3;
    typedef enum logic [2:0] {IDLE, ACC, WAIT, RESP, TURN} state_t;
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port SRAM responder behind the arbiter with configurable read/write wait states.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_AW  = 16,
    parameter int WAIT_RD = 2,
    parameter int WAIT_WR = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BUS_W-1:0]  addr_m,
    input  logic [BUS_W-1:0]  dout_m,
    input  logic              req_m,
    input  logic              wr_m,
    output logic [BUS_W-1:0]  din_m,
    output logic              rdy_m,
    output logic              bus_err,
    output logic              sram_en,
    output logic              sram_we,
    output logic [MEM_AW-1:0] sram_addr,
    output logic [BUS_W-1:0]  sram_wdata,
    input  logic [BUS_W-1:0]  sram_rdata
);
    state_t state, state_n;
    logic [3:0] cnt, wait_sel;
    logic [MEM_AW-1:0] idx;
    logic [BUS_W-1:0] wdata, data_q, rd_data;
    logic wr, oor, acc_q, bad_addr;

    assign bad_addr   = |addr_m[BUS_W-1:MEM_AW+OFF_W] || |addr_m[OFF_W-1:0];
    assign wait_sel   = wr ? 4'(WAIT_WR) : 4'(WAIT_RD);
    // SRAM data is only valid in the cycle right after ACC; bypass the capture register then
    assign rd_data    = acc_q ? sram_rdata : data_q;
    assign sram_en    = state == ACC && !oor;
    assign sram_we    = state == ACC && !oor && wr;
    assign sram_addr  = idx;
    assign sram_wdata = wdata;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = req_m ? ACC : IDLE;
            ACC:     state_n = wait_sel != 4'd0 ? WAIT : RESP;
            WAIT:    state_n = cnt == 4'd1 ? RESP : WAIT;
            RESP:    state_n = TURN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            wdata   <= '0;
            wr      <= 1'b0;
            oor     <= 1'b0;
            acc_q   <= 1'b0;
            data_q  <= '0;
            din_m   <= '0;
            rdy_m   <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state   <= state_n;
            acc_q   <= state == ACC;
            rdy_m   <= state == RESP;
            bus_err <= state == RESP && oor;
            if (acc_q)
                data_q <= sram_rdata;
            if (state == IDLE && req_m) begin
                idx   <= addr_m[MEM_AW+OFF_W-1:OFF_W];
                wdata <= dout_m;
                wr    <= wr_m;
                oor   <= bad_addr;
            end
            if (state == ACC)
                cnt <= wait_sel;
            else if (state == WAIT)
                cnt <= cnt - 4'd1;
            if (state == RESP && !wr)
                din_m <= oor ? '0 : rd_data;
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table-driven check of mem_ctrl with three wait-state configurations and behavioural SRAMs.
module tb_mem_ctrl;
    import mem_pkg::*;

    typedef struct {
        int          k;
        logic [63:0] a;
        logic [63:0] d;
        logic        w;
        logic        churn;
        int          rdy_at;
        logic [63:0] din;
        logic        berr;
        int          en_n;
        int          we_n;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [63:0] addr [3];
    logic [63:0] dout [3];
    logic req [3];
    logic wr [3];
    wire [63:0] din [3];
    wire [63:0] wdat [3];
    wire [15:0] saddr [3];
    wire rdy [3];
    wire berr [3];
    wire en [3];
    wire we [3];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // instance 0: RD=2/WR=1, instance 1: RD=0, instance 2: RD=4
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [63:0] mem [0:65535];
        logic [63:0] rd;
        mem_ctrl #(.MEM_AW(16), .WAIT_RD(g == 0 ? 2 : g == 1 ? 0 : 4), .WAIT_WR(1)) dut (
            .clk(clk), .reset(rst), .addr_m(addr[g]), .dout_m(dout[g]), .req_m(req[g]),
            .wr_m(wr[g]), .din_m(din[g]), .rdy_m(rdy[g]), .bus_err(berr[g]), .sram_en(en[g]),
            .sram_we(we[g]), .sram_addr(saddr[g]), .sram_wdata(wdat[g]), .sram_rdata(rd)
        );
        always @(posedge clk)
            if (en[g]) begin
                if (we[g]) mem[saddr[g]] <= wdat[g];
                else rd <= mem[saddr[g]];
            end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // t counts edges after the accepting edge; sram signals seen at t are sampled by edge t+1
    task automatic do_txn(input int k, input logic [63:0] a, input logic [63:0] d, input logic w,
                          input logic churn, output int rdy_at, output int en_n, output int we_n,
                          output int en_at, output logic [15:0] sa);
        rdy_at = -1; en_n = 0; we_n = 0; en_at = -1; sa = '0;
        @(negedge clk);
        addr[k] = a; dout[k] = d; wr[k] = w; req[k] = 1'b1;
        @(posedge clk);
        for (int t = 0; t < 40 && rdy_at < 0; t++) begin
            @(negedge clk);
            if (en[k]) begin
                en_n++;
                if (en_at < 0) begin en_at = t + 1; sa = saddr[k]; end
            end
            if (we[k]) we_n++;
            if (rdy[k]) rdy_at = t;
            if (churn) begin
                addr[k] = addr[k] ^ 64'h18; wr[k] = ~wr[k]; dout[k] = ~dout[k];
            end
        end
        req[k] = 1'b0;
    endtask

    initial begin
        vec_t v [12];
        int ra, en_n, we_n, en_at, rc;
        logic [15:0] sa;
        logic [63:0] ea;
        logic [31:0] rm, em;
        v[0]  = '{0, 64'h40,          64'hDEADBEEF_CAFEF00D, 1'b1, 1'b0, 3, 64'h0,                 1'b0, 1, 1};
        v[1]  = '{0, 64'h40,          64'h0,                 1'b0, 1'b0, 4, 64'hDEADBEEF_CAFEF00D, 1'b0, 1, 0};
        v[2]  = '{0, 64'h48,          64'h1111,              1'b1, 1'b0, 3, 64'hDEADBEEF_CAFEF00D, 1'b0, 1, 1};
        v[3]  = '{0, 64'h1_0000_0000, 64'h0,                 1'b0, 1'b0, 4, 64'h0,                 1'b1, 0, 0};
        v[4]  = '{0, 64'h4,           64'h55,                1'b1, 1'b0, 3, 64'h0,                 1'b1, 0, 0};
        v[5]  = '{1, 64'h8,           64'h01234567_89ABCDEF, 1'b1, 1'b0, 3, 64'h0,                 1'b0, 1, 1};
        v[6]  = '{1, 64'h8,           64'h0,                 1'b0, 1'b0, 2, 64'h01234567_89ABCDEF, 1'b0, 1, 0};
        v[7]  = '{0, 64'h48,          64'h0,                 1'b0, 1'b1, 4, 64'h1111,              1'b0, 1, 0};
        v[8]  = '{0, 64'h50,          64'hAAAA,              1'b1, 1'b1, 3, 64'h1111,              1'b0, 1, 1};
        v[9]  = '{0, 64'h50,          64'h0,                 1'b0, 1'b0, 4, 64'hAAAA,              1'b0, 1, 0};
        v[10] = '{0, 64'h48,          64'h0,                 1'b0, 1'b0, 4, 64'h1111,              1'b0, 1, 0};
        v[11] = '{2, 64'h10,          64'h1234,              1'b1, 1'b0, 3, 64'h0,                 1'b0, 1, 1};
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; dout[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset din", din[0], 64'h0);
        chk("reset rdy", 64'(rdy[0]), 64'h0);
        chk("reset bus_err", 64'(berr[0]), 64'h0);
        chk("reset sram_en", 64'(en[0]), 64'h0);
        chk("reset sram_we", 64'(we[0]), 64'h0);
        chk("reset sram_addr", 64'(saddr[0]), 64'h0);
        chk("reset sram_wdata", wdat[0], 64'h0);
        chk("reset state", 64'(g_dut[0].dut.state), 64'(IDLE));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            do_txn(v[i].k, v[i].a, v[i].d, v[i].w, v[i].churn, ra, en_n, we_n, en_at, sa);
            chk($sformatf("v%0d rdy_at", i), 64'(ra), 64'(v[i].rdy_at));
            chk($sformatf("v%0d din", i), din[v[i].k], v[i].din);
            chk($sformatf("v%0d bus_err", i), 64'(berr[v[i].k]), 64'(v[i].berr));
            chk($sformatf("v%0d en_count", i), 64'(en_n), 64'(v[i].en_n));
            chk($sformatf("v%0d we_count", i), 64'(we_n), 64'(v[i].we_n));
            if (v[i].en_n > 0) begin
                ea = v[i].a;
                chk($sformatf("v%0d en_cycle", i), 64'(en_at), 64'd1);
                chk($sformatf("v%0d sram_addr", i), 64'(sa), 64'(ea[18:3]));
            end
            repeat (2) @(negedge clk);
        end

        // back-to-back: req held through TURN; second access only from the following IDLE
        @(negedge clk);
        addr[0] = 64'h40; wr[0] = 1'b0; req[0] = 1'b1;
        @(posedge clk);
        rm = '0; em = '0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            rm[t] = rdy[0];
            em[t] = en[0];
        end
        req[0] = 1'b0;
        chk("b2b rdy cycles", 64'(rm), 64'h410);
        chk("b2b en cycles", 64'(em), 64'h41);
        chk("b2b din", din[0], 64'hDEADBEEF_CAFEF00D);
        repeat (2) @(negedge clk);

        // reset in WAIT drops the read with no completion
        @(negedge clk);
        addr[2] = 64'h10; wr[2] = 1'b0; req[2] = 1'b1;
        @(posedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b1; req[2] = 1'b0;
        @(negedge clk);
        chk("rst state", 64'(g_dut[2].dut.state), 64'(IDLE));
        chk("rst rdy", 64'(rdy[2]), 64'h0);
        rst = 1'b0;
        rc = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (rdy[2]) rc++;
        end
        chk("rst no rdy", 64'(rc), 64'h0);
        do_txn(2, 64'h10, 64'h0, 1'b0, 1'b0, ra, en_n, we_n, en_at, sa);
        chk("post-rst rdy_at", 64'(ra), 64'd6);
        chk("post-rst din", din[2], 64'h1234);
        chk("post-rst en_count", 64'(en_n), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
